// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// Module      : md_sched
// Description : HI/LO multiply/divide sequencer. Holds the md unit busy for a
//               fixed latency, commits HI/LO at the end, requests D-stage stall.
// Revision    : 1.0 - initial release
// ============================================================================
module md_sched #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    localparam logic [3:0] c_mult_cyc = 4'(MULT_CYC);
    localparam logic [3:0] c_div_cyc  = 4'(DIV_CYC);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    logic [3:0]  r_cnt;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;

    logic [3:0]  w_cnt_nxt;
    logic        w_done_nxt;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [31:0] w_pend_hi_nxt;
    logic [31:0] w_pend_lo_nxt;
    logic        w_pend_wr_nxt;

    state_t      w_state;
    logic        w_busy;
    logic        w_is_md_op;

    // Arithmetic datapath: the result is captured at the issue edge.
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_wr;
    logic [3:0]  w_res_cyc;

    assign w_busy     = (r_cnt != 4'd0);
    assign w_state    = w_busy ? S_RUN : S_IDLE;
    assign w_is_md_op = (op >= c_op_mult) && (op <= c_op_divu);

    assign w_prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide works on magnitudes so that 0x80000000 / -1 wraps cleanly.
    assign w_a_neg = (op == c_op_div) & rs_val[31];
    assign w_b_neg = (op == c_op_div) & rt_val[31];
    assign w_a_mag = w_a_neg ? (~rs_val + 32'd1) : rs_val;
    assign w_b_mag = w_b_neg ? (~rt_val + 32'd1) : rt_val;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;
    assign w_quot  = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem   = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        w_res_hi  = 32'd0;
        w_res_lo  = 32'd0;
        w_res_wr  = 1'b0;
        w_res_cyc = c_mult_cyc;
        case (op)
            c_op_mult: begin
                {w_res_hi, w_res_lo} = w_prod_s;
                w_res_wr = 1'b1;
            end
            c_op_multu: begin
                {w_res_hi, w_res_lo} = w_prod_u;
                w_res_wr = 1'b1;
            end
            c_op_div, c_op_divu: begin
                w_res_hi  = w_rem;
                w_res_lo  = w_quot;
                w_res_wr  = |rt_val;
                w_res_cyc = c_div_cyc;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = 1'b0;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_wr_nxt = r_pend_wr;
        case (w_state)
            S_IDLE: begin
                if (start) begin
                    if (w_is_md_op) begin
                        w_pend_hi_nxt = w_res_hi;
                        w_pend_lo_nxt = w_res_lo;
                        w_pend_wr_nxt = w_res_wr;
                        w_cnt_nxt     = w_res_cyc;
                    end else if (op == c_op_mthi) begin
                        w_hi_nxt = rs_val;
                    end else if (op == c_op_mtlo) begin
                        w_lo_nxt = rs_val;
                    end
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_done_nxt = 1'b1;
                    // A zero divisor still completes, but leaves HI/LO untouched.
                    if (r_pend_wr) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= 4'd0;
            r_done    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_wr <= w_pend_wr_nxt;
        end
    end

    assign busy  = w_busy;
    assign stall = d_is_md & (w_busy | (start & w_is_md_op));
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_sched
// Description : Self-checking bench for md_sched against a timestamp-based
//               behavioural model, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_sched;

    localparam int CLK_P    = 10;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        d_is_md = 1'b0;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // Model state: a pending result with the absolute time it becomes due.
    logic        m_pend = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    logic        m_keep = 1'b0;
    time         m_commit_t = 0;

    md_sched #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .d_is_md(d_is_md),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #(CLK_P / 2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic keep);
        longint sa, sb, q, r;
        logic [63:0] p;
        h = 32'd0; l = 32'd0; keep = 1'b0;
        case (o)
            3'd1: begin
                sa = $signed(a); sb = $signed(b);
                p = sa * sb;
                h = p[63:32]; l = p[31:0];
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32]; l = p[31:0];
            end
            3'd3: begin
                if (b == 32'd0) keep = 1'b1;
                else begin
                    sa = $signed(a); sb = $signed(b);
                    q = sa / sb; r = sa % sb;
                    l = q[31:0]; h = r[31:0];
                end
            end
            3'd4: begin
                if (b == 32'd0) keep = 1'b1;
                else begin
                    l = a / b; h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend = 1'b0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
        end else begin
            m_done = 1'b0;
            if (m_pend && $time == m_commit_t) begin
                m_pend = 1'b0;
                m_done = 1'b1;
                if (!m_keep) begin m_hi = m_phi; m_lo = m_plo; end
            end else if (!m_pend && start) begin
                if (op >= 3'd1 && op <= 3'd4) begin
                    calc(op, rs_val, rt_val, m_phi, m_plo, m_keep);
                    m_pend = 1'b1;
                    m_commit_t = $time + CLK_P * ((op >= 3'd3) ? DIV_CYC : MULT_CYC);
                end else if (op == 3'd5) m_hi = rs_val;
                else if (op == 3'd6) m_lo = rs_val;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_pend});
            check("stall", {31'd0, stall},
                  {31'd0, d_is_md & (m_pend | (start & (op >= 3'd1) & (op <= 3'd4)))});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #2;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #2;
        start = 1'b0; op = 3'd0;
    endtask

    task automatic run_count(output int nb);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nb++;
            else break;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nb;
        int ndone;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        issue(3'd1, 32'hFFFF_FFFD, 32'd5);
        run_count(nb);
        check("mult_busy_cycles", nb, 32'd5);
        check("mult_done", {31'd0, done}, 32'd1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_count(nb);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        d_is_md = 1'b1;
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        run_count(nb);
        check("div_busy_cycles", nb, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_stall_after", {31'd0, stall}, 32'd0);
        d_is_md = 1'b0;

        issue(3'd4, 32'd7, 32'd2);
        run_count(nb);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        issue(3'd3, 32'd100, 32'd7);
        issue(3'd1, 32'd3, 32'd3);
        run_count(nb);
        check("div_ignore_busy_tail", nb, 32'd8);
        check("div_ignore_lo", lo, 32'd14);
        check("div_ignore_hi", hi, 32'd2);

        issue(3'd3, 32'd55, 32'd0);
        run_count(nb);
        check("div0_busy_cycles", nb, 32'd10);
        check("div0_done", {31'd0, done}, 32'd1);
        check("div0_lo_kept", lo, 32'd14);
        check("div0_hi_kept", hi, 32'd2);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_count(nb);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);

        issue(3'd5, 32'h0000_1234, 32'd0);
        @(negedge clk);
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'hCAFE_F00D, 32'd0);
        @(negedge clk);
        check("mtlo_lo", lo, 32'hCAFE_F00D);

        issue(3'd1, 32'd7, 32'd9);
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_hi", hi, 32'd0);
        check("rstmid_lo", lo, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #2 reset = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rstmid_no_done", ndone, 32'd0);

        repeat (600) begin
            @(posedge clk); #2;
            start   = ($urandom_range(0, 2) == 0);
            op      = 3'($urandom_range(0, 7));
            rs_val  = pick();
            rt_val  = pick();
            d_is_md = 1'($urandom_range(0, 1));
            reset   = ($urandom_range(0, 149) == 0);
        end
        @(posedge clk); #2;
        reset = 1'b0; start = 1'b0; op = 3'd0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
